// File: rtl/mem_access_sequencer.sv
// mem_access_sequencer
//
// Arbitrates and sequences the single shared instruction/data memory between
// the instruction-fetch requester and the load/store requester of the
// multicycle CPU. One request is served at a time. The block drives the memory
// address, write-data and write-enable lines and counts out the fixed read
// latency. It then returns the captured read word with a one-cycle done pulse.
//
// Optional feature (compile-time macro MEMSEQ_MISALIGN_CHECK_EN):
//   When defined, a request with addr[1:0] != 0 skips the memory access and
//   completes immediately with err=1. When undefined, err is tied low.
//
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   if_req/if_addr           fetch read request (held until if_done)
//   if_done/if_rdata         fetch completion pulse / last fetched word
//   d_req/d_we/d_addr/d_wdata  data request (held until d_done)
//   d_done/d_rdata           data completion pulse / last loaded word
//   err                      misaligned-access flag, valid with a done pulse
//   mem_addr/mem_wdata       registered memory address / write data
//   mem_wr                   memory write enable
//   mem_rdata                memory read data
//   busy, estado             state != IDLE, current state code (debug)
module mem_access_sequencer #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int READ_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic              err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic [1:0]        estado
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [3:0] LAT_INIT = 4'(READ_LAT);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              last_owner_q, last_owner_d;  // 1 = data port, 0 = fetch
    logic              owner_q, owner_d;            // owner of current transaction
    logic              we_q, we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

    // Data wins when it is the only requester, or on a tie when fetch was
    // served last. last_owner resets to fetch, so the first tie goes to data.
    logic              grant_data;
    logic [ADDR_W-1:0] grant_addr;
    assign grant_data = d_req & (~if_req | ~last_owner_q);
    assign grant_addr = grant_data ? d_addr : if_addr;

`ifdef MEMSEQ_MISALIGN_CHECK_EN
    logic err_q, err_d;
    logic misal;
    assign misal = |grant_addr[1:0];
`endif

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            last_owner_q <= 1'b0;
            owner_q      <= 1'b0;
            we_q         <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            if_rdata_q   <= '0;
            d_rdata_q    <= '0;
`ifdef MEMSEQ_MISALIGN_CHECK_EN
            err_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_owner_q <= last_owner_d;
            owner_q      <= owner_d;
            we_q         <= we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            if_rdata_q   <= if_rdata_d;
            d_rdata_q    <= d_rdata_d;
`ifdef MEMSEQ_MISALIGN_CHECK_EN
            err_q        <= err_d;
`endif
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_owner_d = last_owner_q;
        owner_d      = owner_q;
        we_d         = we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        if_rdata_d   = if_rdata_q;
        d_rdata_d    = d_rdata_q;
`ifdef MEMSEQ_MISALIGN_CHECK_EN
        err_d        = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (if_req | d_req) begin
                    owner_d      = grant_data;
                    last_owner_d = grant_data;
                    we_d         = grant_data & d_we;  // fetch is always a read
                    mem_addr_d   = grant_addr;
                    if (grant_data) begin
                        mem_wdata_d = d_wdata;
                    end
`ifdef MEMSEQ_MISALIGN_CHECK_EN
                    err_d   = misal;
                    state_d = misal ? S_DONE : S_ACCESS;
`else
                    state_d = S_ACCESS;
`endif
                end
            end
            S_ACCESS: begin
                if (we_q) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d   = LAT_INIT;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                // Last wait cycle: memory data is valid now.
                if (cnt_q == 4'd1) begin
                    if (owner_q) begin
                        d_rdata_d = mem_rdata;
                    end else begin
                        if_rdata_d = mem_rdata;
                    end
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs
    always_comb begin
        busy    = (state_q != S_IDLE);
        estado  = state_q;
        mem_wr  = (state_q == S_ACCESS) & we_q;
        if_done = (state_q == S_DONE) & ~owner_q;
        d_done  = (state_q == S_DONE) & owner_q;
`ifdef MEMSEQ_MISALIGN_CHECK_EN
        err     = (state_q == S_DONE) & err_q;
`else
        err     = 1'b0;
`endif
    end

    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;

endmodule
